// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: reset vector, main-decoder opcodes, fetch FSM states.
// Build option FETCH_ADEL_EN (see inst_fetch) is the only configuration macro.
package cpu_defs_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD
    } fetch_state_t;

    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a new instruction, hold under stall, or bubble.
module if_id_reg
    import cpu_defs_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        stall,
    input  logic [31:0] load_inst,
    input  logic [31:0] load_pc,
    input  logic        load_adel,
    output logic        valid,
    output logic [31:0] inst,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        adel
);

    // pc_plus4 is registered so that it reads 0 out of reset like the other fields
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid    <= 1'b0;
            inst     <= '0;
            pc       <= '0;
            pc_plus4 <= '0;
            adel     <= 1'b0;
        end else if (load) begin
            valid    <= 1'b1;
            inst     <= load_inst;
            pc       <= load_pc;
            pc_plus4 <= pc_next(load_pc);
            adel     <= load_adel;
        end else if (!stall) begin
            valid    <= 1'b0;
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: single-outstanding SRAM fetch FSM with skid buffer and redirect.
// Define FETCH_ADEL_EN to trap misaligned fetch addresses instead of issuing them.
module inst_fetch
    import cpu_defs_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [5:0]  id_op,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        id_adel
);

    fetch_state_t state;
    logic [31:0]  fetch_pc;
    logic [31:0]  skid;
    logic         discard;
    logic [31:0]  redirect_target;
    logic         target_ok;
    logic         load;
    logic [31:0]  load_inst;
    logic         load_adel;
`ifdef FETCH_ADEL_EN
    logic         adel_done;
`endif

    assign redirect_target = redirect_valid ? redirect_pc : fetch_pc;

`ifdef FETCH_ADEL_EN
    assign target_ok = (redirect_target[1:0] == 2'b00);
`else
    assign target_ok = 1'b1;
`endif

    always_comb begin
        load      = 1'b0;
        load_inst = inst_rdata;
        load_adel = 1'b0;
        case (state)
            FS_WAIT: load = inst_data_ok && !discard && !redirect_valid && !stall;
            FS_HOLD: begin
                load      = !redirect_valid && !stall;
                load_inst = skid;
            end
`ifdef FETCH_ADEL_EN
            FS_IDLE: begin
                load      = (fetch_pc[1:0] != 2'b00) && !adel_done && !redirect_valid && !stall;
                load_inst = '0;
                load_adel = 1'b1;
            end
`endif
            default: load = 1'b0;
        endcase
    end

    // A restart (from IDLE, a dropped response, or a redirect out of HOLD) goes to
    // REQ at redirect_target, or parks in IDLE when that target cannot be fetched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FS_IDLE;
            fetch_pc  <= RESET_PC;
            skid      <= '0;
            discard   <= 1'b0;
            inst_req  <= 1'b0;
            inst_addr <= RESET_PC;
`ifdef FETCH_ADEL_EN
            adel_done <= 1'b0;
`endif
        end else begin
            case (state)
                FS_IDLE: begin
                    fetch_pc <= redirect_target;
                    if (target_ok) begin
                        state     <= FS_REQ;
                        inst_req  <= 1'b1;
                        inst_addr <= redirect_target;
`ifdef FETCH_ADEL_EN
                        adel_done <= 1'b0;
                    end else if (redirect_valid) begin
                        adel_done <= 1'b0;
                    end else if (load) begin
                        adel_done <= 1'b1;
`endif
                    end
                end
                FS_REQ: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        discard  <= 1'b1;
                    end
                    if (inst_addr_ok) begin
                        state    <= FS_WAIT;
                        inst_req <= 1'b0;
                    end
                end
                FS_WAIT: begin
                    if (inst_data_ok) begin
                        if (discard || redirect_valid) begin
                            discard  <= 1'b0;
                            fetch_pc <= redirect_target;
                            if (target_ok) begin
                                state     <= FS_REQ;
                                inst_req  <= 1'b1;
                                inst_addr <= redirect_target;
                            end else begin
                                state     <= FS_IDLE;
                            end
                        end else if (!stall) begin
                            fetch_pc  <= pc_next(fetch_pc);
                            state     <= FS_REQ;
                            inst_req  <= 1'b1;
                            inst_addr <= pc_next(fetch_pc);
                        end else begin
                            skid  <= inst_rdata;
                            state <= FS_HOLD;
                        end
                    end else if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        discard  <= 1'b1;
                    end
                end
                FS_HOLD: begin
                    if (redirect_valid) begin
                        fetch_pc <= redirect_pc;
                        if (target_ok) begin
                            state     <= FS_REQ;
                            inst_req  <= 1'b1;
                            inst_addr <= redirect_pc;
                        end else begin
                            state     <= FS_IDLE;
                        end
                    end else if (!stall) begin
                        fetch_pc  <= pc_next(fetch_pc);
                        state     <= FS_REQ;
                        inst_req  <= 1'b1;
                        inst_addr <= pc_next(fetch_pc);
                    end
                end
                default: begin
                    state    <= FS_IDLE;
                    inst_req <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .stall     (stall),
        .load_inst (load_inst),
        .load_pc   (fetch_pc),
        .load_adel (load_adel),
        .valid     (id_valid),
        .inst      (id_inst),
        .pc        (id_pc),
        .pc_plus4  (id_pc_plus4),
        .adel      (id_adel)
    );

    assign id_op = id_inst[31:26];

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed scenarios plus a randomized stream check.
// Define FETCH_ADEL_EN for both RTL and bench to exercise the misaligned-fetch trap.
module tb_inst_fetch;
    import cpu_defs_pkg::*;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = '0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [5:0]  id_op;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        id_adel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_req       (inst_req),
        .inst_addr      (inst_addr),
        .inst_addr_ok   (inst_addr_ok),
        .inst_data_ok   (inst_data_ok),
        .inst_rdata     (inst_rdata),
        .id_valid       (id_valid),
        .id_inst        (id_inst),
        .id_op          (id_op),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .id_adel        (id_adel)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[9:4], a[27:2]} ^ 32'h1357_9BDF;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic aok, input logic dok, input logic [31:0] rd);
        inst_addr_ok = aok;
        inst_data_ok = dok;
        inst_rdata   = rd;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        drive(1'b0, 1'b0, '0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        cyc();
        checks++;
        if ({inst_req, id_valid, id_adel, id_op, id_inst, id_pc, id_pc_plus4} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%b v=%b adel=%b op=%h inst=%h pc=%h p4=%h, expected all 0",
                     inst_req, id_valid, id_adel, id_op, id_inst, id_pc, id_pc_plus4);
        end
        checks++;
        if (inst_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_addr: got %h expected %h", inst_addr, RST_PC);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        cyc();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== RST_PC) begin
            errors++;
            $display("FAIL first_req: got req=%b addr=%h expected 1 %h", inst_req, inst_addr, RST_PC);
        end
        drive(1'b1, 1'b0, '0);
        cyc();
        checks++;
        if (inst_req !== 1'b0) begin
            errors++;
            $display("FAIL first_req_drop: got %b expected 0", inst_req);
        end
        drive(1'b0, 1'b1, 32'h8C01_0004);
        cyc();
        drive(1'b0, 1'b0, '0);
        checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h8C01_0004 || id_op !== OP_LW) begin
            errors++;
            $display("FAIL first_inst: got v=%b inst=%h op=%b expected 1 8c010004 %b",
                     id_valid, id_inst, id_op, OP_LW);
        end
        checks++;
        if (id_pc !== RST_PC || id_pc_plus4 !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL first_pc: got pc=%h p4=%h expected %h bfc00004", id_pc, id_pc_plus4, RST_PC);
        end
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL first_next_addr: got req=%b addr=%h expected 1 bfc00004", inst_req, inst_addr);
        end
    endtask

    task automatic test_stall_hold();
        do_reset();
        cyc();
        drive(1'b1, 1'b0, '0);
        cyc();
        stall = 1'b1;
        drive(1'b0, 1'b1, 32'h0022_1820);
        for (int i = 0; i < 3; i++) begin
            cyc();
            drive(1'b0, 1'b0, 32'hDEAD_BEEF);
            checks++;
            if (id_valid !== 1'b0 || id_inst !== '0 || id_pc !== '0 || inst_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got v=%b inst=%h pc=%h req=%b expected 0 0 0 0",
                         i, id_valid, id_inst, id_pc, inst_req);
            end
        end
        stall = 1'b0;
        cyc();
        checks++;
        if (id_valid !== 1'b1 || id_inst !== 32'h0022_1820 || id_pc !== RST_PC) begin
            errors++;
            $display("FAIL skid_load: got v=%b inst=%h pc=%h expected 1 00221820 %h",
                     id_valid, id_inst, id_pc, RST_PC);
        end
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'hBFC0_0004) begin
            errors++;
            $display("FAIL skid_next_addr: got req=%b addr=%h expected 1 bfc00004", inst_req, inst_addr);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        cyc();
        drive(1'b1, 1'b0, '0);
        cyc();
        drive(1'b0, 1'b0, '0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0100;
        cyc();
        redirect_valid = 1'b0;
        drive(1'b0, 1'b1, 32'h2001_0005);
        cyc();
        drive(1'b0, 1'b0, '0);
        checks++;
        if (id_valid !== 1'b0) begin
            errors++;
            $display("FAIL redir_drop_valid: got %b expected 0", id_valid);
        end
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== 32'h8000_0100) begin
            errors++;
            $display("FAIL redir_next_addr: got req=%b addr=%h expected 1 80000100", inst_req, inst_addr);
        end
    endtask

    task automatic test_double_redirect();
        do_reset();
        cyc();
        drive(1'b1, 1'b0, '0);
        cyc();
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0200;
        drive(1'b0, 1'b1, 32'h1111_1111);
        cyc();
        redirect_valid = 1'b0;
        drive(1'b0, 1'b0, '0);
        checks++;
        if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_0200) begin
            errors++;
            $display("FAIL coincident_redir: got v=%b req=%b addr=%h expected 0 1 80000200",
                     id_valid, inst_req, inst_addr);
        end
        drive(1'b1, 1'b0, '0);
        cyc();
        drive(1'b0, 1'b0, '0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0300;
        cyc();
        redirect_valid = 1'b0;
        drive(1'b0, 1'b1, 32'h2222_2222);
        cyc();
        drive(1'b0, 1'b0, '0);
        checks++;
        if (id_valid !== 1'b0 || inst_req !== 1'b1 || inst_addr !== 32'h8000_0300) begin
            errors++;
            $display("FAIL second_redir: got v=%b req=%b addr=%h expected 0 1 80000300",
                     id_valid, inst_req, inst_addr);
        end
        drive(1'b1, 1'b0, '0);
        cyc();
        drive(1'b0, 1'b1, 32'h0800_0040);
        cyc();
        drive(1'b0, 1'b0, '0);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h8000_0300 || id_inst !== 32'h0800_0040 || id_op !== OP_J) begin
            errors++;
            $display("FAIL after_redir_load: got v=%b pc=%h inst=%h op=%b expected 1 80000300 08000040 %b",
                     id_valid, id_pc, id_inst, id_op, OP_J);
        end
    endtask

    task automatic test_reset_mid_req();
        do_reset();
        cyc();
        drive(1'b1, 1'b0, '0);
        cyc();
        drive(1'b0, 1'b1, 32'h8C01_0004);
        cyc();
        drive(1'b0, 1'b0, '0);
        rst = 1'b1;
        #1;
        checks++;
        if (inst_req !== 1'b0 || id_valid !== 1'b0 || inst_addr !== RST_PC) begin
            errors++;
            $display("FAIL async_reset: got req=%b v=%b addr=%h expected 0 0 %h",
                     inst_req, id_valid, inst_addr, RST_PC);
        end
        cyc();
        rst = 1'b0;
        cyc();
        checks++;
        if (inst_req !== 1'b1 || inst_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_refetch: got req=%b addr=%h expected 1 %h", inst_req, inst_addr, RST_PC);
        end
    endtask

`ifdef FETCH_ADEL_EN
    task automatic test_adel();
        do_reset();
        cyc();
        drive(1'b1, 1'b0, '0);
        cyc();
        drive(1'b0, 1'b0, '0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h8000_0102;
        cyc();
        redirect_valid = 1'b0;
        drive(1'b0, 1'b1, 32'h3333_3333);
        cyc();
        drive(1'b0, 1'b0, '0);
        cyc();
        checks++;
        if (id_valid !== 1'b1 || id_adel !== 1'b1 || id_inst !== '0 || id_pc !== 32'h8000_0102) begin
            errors++;
            $display("FAIL adel_load: got v=%b adel=%b inst=%h pc=%h expected 1 1 0 80000102",
                     id_valid, id_adel, id_inst, id_pc);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (inst_req !== 1'b0) begin
                errors++;
                $display("FAIL adel_no_req[%0d]: got %b expected 0", i, inst_req);
            end
            cyc();
        end
    endtask
`endif

    // Stream-level model: after a redirect the next delivered instruction is the
    // target; otherwise each delivered pc is the previous one plus 4 (mod 2^32).
    task automatic test_random();
        logic [31:0] exp_pc, w, prev_addr, pend_addr;
        logic [31:0] s_inst, s_pc, s_p4;
        logic        s_valid, prev_stall, prev_pending, outstanding;
        int          wait_cnt, delivered;
        do_reset();
        exp_pc = RST_PC;
        prev_stall = 1'b0;
        prev_pending = 1'b0;
        prev_addr = '0;
        outstanding = 1'b0;
        pend_addr = '0;
        wait_cnt = 0;
        delivered = 0;
        s_valid = 1'b0;
        s_inst = '0;
        s_pc = '0;
        s_p4 = '0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (prev_stall) begin
                checks++;
                if ({id_valid, id_inst, id_pc, id_pc_plus4} !== {s_valid, s_inst, s_pc, s_p4}) begin
                    errors++;
                    $display("FAIL rnd_hold: got v=%b inst=%h pc=%h expected v=%b inst=%h pc=%h",
                             id_valid, id_inst, id_pc, s_valid, s_inst, s_pc);
                end
            end else if (id_valid) begin
                w = mem_word(exp_pc);
                checks++;
                if (id_pc !== exp_pc || id_pc_plus4 !== exp_pc + 32'd4) begin
                    errors++;
                    $display("FAIL rnd_pc: got pc=%h p4=%h expected %h %h", id_pc, id_pc_plus4, exp_pc, exp_pc + 32'd4);
                end
                checks++;
                if (id_inst !== w || id_op !== w[31:26] || id_adel !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_inst: got inst=%h op=%b adel=%b expected %h %b 0",
                             id_inst, id_op, id_adel, w, w[31:26]);
                end
                exp_pc = exp_pc + 32'd4;
                delivered++;
            end
            if (prev_pending) begin
                checks++;
                if (inst_req !== 1'b1 || inst_addr !== prev_addr) begin
                    errors++;
                    $display("FAIL rnd_addr_stable: got req=%b addr=%h expected 1 %h", inst_req, inst_addr, prev_addr);
                end
            end
            checks++;
            if (inst_req === 1'b1 && outstanding) begin
                errors++;
                $display("FAIL rnd_outstanding: got req=1 with a transaction pending, expected req=0");
            end
            s_valid = id_valid;
            s_inst = id_inst;
            s_pc = id_pc;
            s_p4 = id_pc_plus4;
            drive(1'b0, 1'b0, $urandom);
            if (outstanding) begin
                if (wait_cnt == 0) begin
                    inst_data_ok = 1'b1;
                    inst_rdata = mem_word(pend_addr);
                    outstanding = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end else if (inst_req === 1'b1 && $urandom_range(0, 1) == 1) begin
                inst_addr_ok = 1'b1;
                outstanding = 1'b1;
                pend_addr = inst_addr;
                wait_cnt = $urandom_range(0, 2);
            end
            prev_pending = inst_req && !inst_addr_ok;
            prev_addr = inst_addr;
            stall = ($urandom_range(0, 3) == 0);
            redirect_valid = ($urandom_range(0, 31) == 0);
            if (redirect_valid) begin
                redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
                exp_pc = redirect_pc;
            end
            prev_stall = stall;
        end
        stall = 1'b0;
        redirect_valid = 1'b0;
        drive(1'b0, 1'b0, '0);
        checks++;
        if (delivered < 100) begin
            errors++;
            $display("FAIL rnd_progress: got %0d instructions delivered, expected at least 100", delivered);
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_stall_hold();
        test_redirect_wait();
        test_double_redirect();
        test_reset_mid_req();
`ifdef FETCH_ADEL_EN
        test_adel();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter: RESET_PC, 32'hBFC0_0000, first fetch address after reset.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 stall  in  1  decode stage cannot accept a new instruction this cycle.
REQ-005 redirect_valid  in  1  branch/jump taken; next fetch from redirect_pc.
REQ-006 redirect_pc  in  32  redirect target.
REQ-007 inst_req  out  1  instruction-SRAM request.
REQ-008 inst_addr  out  32  request address (byte address).
REQ-009 inst_addr_ok  in  1  request accepted this cycle.
REQ-010 inst_data_ok  in  1  read data valid this cycle.
REQ-011 inst_rdata  in  32  read data.
REQ-012 id_valid  out  1  IF/ID register holds a valid instruction.
REQ-013 id_inst  out  32  instruction word.
REQ-014 id_op  out  6  id_inst[31:26], feeds the main decoder op input.
REQ-015 id_pc  out  32  address of id_inst.
REQ-016 id_pc_plus4  out  32  id_pc + 4, modulo 2^32.
REQ-017 id_adel  out  1  fetch address misaligned (see Configuration).

Function
REQ-018 FSM states: IDLE, REQ, WAIT, HOLD.
REQ-019 IDLE: entered on reset; next cycle -> REQ with inst_addr = fetch_pc.
REQ-020 REQ: inst_req=1, inst_addr held stable until inst_addr_ok; on inst_addr_ok -> WAIT.
REQ-021 WAIT: inst_req=0; on inst_data_ok: if discard flag set, drop data, clear flag, -> REQ; else if stall=0 load IF/ID, fetch_pc += 4, -> REQ; else latch word in skid buffer, -> HOLD.
REQ-022 HOLD: on stall=0 load IF/ID from skid buffer, fetch_pc += 4, -> REQ.
REQ-023 Load into IF/ID occurs in the same edge as the transition; id_valid=1 the following cycle.
REQ-024 Cycle in which stall=0 and no load occurs: id_valid -> 0 (bubble); stall=1: IF/ID holds all values.
REQ-025 Redirect in REQ or WAIT: fetch_pc <= redirect_pc, discard flag set; in-flight transaction completes on the bus, its data dropped.
REQ-026 Redirect in HOLD: skid buffer invalidated, fetch_pc <= redirect_pc, -> REQ.
REQ-027 Redirect in IDLE: fetch_pc <= redirect_pc, no discard.
REQ-028 Redirect does not alter IF/ID contents already loaded.
REQ-029 Redirect coincident with inst_data_ok in WAIT: data dropped, -> REQ with redirect_pc.
REQ-030 Second redirect before the discard completes: latest redirect_pc wins; only one response dropped.
REQ-031 At most one outstanding transaction at any time.
REQ-032 fetch_pc wraps 32'hFFFF_FFFC -> 32'h0000_0000.

Reset
REQ-033 rst=1 immediately: state=IDLE, fetch_pc=RESET_PC, discard=0, inst_req=0, inst_addr=RESET_PC, id_valid=0, id_inst=0, id_op=0, id_pc=0, id_pc_plus4=0, id_adel=0.
REQ-034 Reset during WAIT: pending response arriving after reset release is ignored (discard=1 set on first cycle after release if a transaction was outstanding is not required; the SRAM is reset by the same rst).

Configuration
REQ-035 Macro FETCH_ADEL_EN defined: fetch_pc[1:0]!=0 issues no request; FSM loads IF/ID directly with id_inst=0, id_adel=1, id_pc=fetch_pc, obeying stall, then waits for redirect in IDLE.
REQ-036 Macro undefined: id_adel tied 0; inst_addr issued with fetch_pc[1:0] unmodified.

Structure
REQ-037 Shared package cpu_defs_pkg: RESET_PC default, opcode constants (R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010), fetch FSM state enum.
REQ-038 One sub-module if_id_reg: IF/ID pipeline register with load/hold/bubble and async reset.

Verification
REQ-039 Reset release, addr_ok and data_ok each 1 cycle later, rdata=32'h8C01_0004 -> inst_addr=BFC0_0000, id_inst=8C01_0004, id_op=100011, id_pc_plus4=BFC0_0004.
REQ-040 stall=1 for 3 cycles at data_ok -> HOLD, id_* unchanged; stall=0 -> skid word loaded, next inst_addr=BFC0_0004.
REQ-041 redirect_pc=8000_0100 during WAIT -> that response dropped, id_valid stays 0, next inst_addr=8000_0100.
REQ-042 redirect coincident with data_ok; then second redirect before its data_ok -> exactly one response dropped, latest target fetched.
REQ-043 rst asserted mid-REQ -> inst_req=0, id_valid=0 same cycle; after release inst_addr=BFC0_0000.
REQ-044 FETCH_ADEL_EN, redirect_pc=8000_0102 -> inst_req stays 0, id_adel=1, id_inst=0, id_pc=8000_0102.
